// File: rtl/bus_sync_pkg.sv
// Shared types and default parameters for the source-side bus crossing launch stage.
package bus_sync_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_REL  = 2'd2
  } bus_sync_state_t;

  localparam int BUS_SYNC_DWIDTH  = 32;
  localparam int BUS_SYNC_STAGES  = 2;
  localparam int BUS_SYNC_TIMEOUT = 1024;
endpackage

// File: rtl/sync_ff_chain.sv
// Single-bit multi-flop synchronizer, reset to 0.
module sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  // Fewer than two flops is not a synchronizer; clamp rather than build a broken chain.
  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] ff;

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[N-2:0], d};
  end

  assign q = ff[N-1];
endmodule

// File: rtl/bus_sync_launch.sv
// Source-domain launch stage: holds a word plus level request until the destination
// acknowledges, then retires it four-phase. Timeout raises a sticky error.
module bus_sync_launch
  import bus_sync_pkg::*;
#(
  parameter int DWIDTH      = BUS_SYNC_DWIDTH,
  parameter int SYNC_STAGES = BUS_SYNC_STAGES,
  parameter int TIMEOUT     = BUS_SYNC_TIMEOUT
) (
  input  logic              i_clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [DWIDTH-1:0] o_sync_data,
  output logic              o_sync_valid,
  input  logic              i_sync_ack,
  output logic              o_busy,
  output logic              o_err,
  input  logic              i_err_clr
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  bus_sync_state_t state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            ack_s;
  logic            accept, retire, err_set, timeout_hit;

  sync_ff_chain #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .i_clk (i_clk),
    .rst_n (rst_n),
    .d     (i_sync_ack),
    .q     (ack_s)
  );

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_MAX);

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    retire  = 1'b0;
    err_set = 1'b0;
    case (state_q)
      S_IDLE: if (i_valid && !ack_s) begin
        accept  = 1'b1;
        state_d = S_REQ;
      end
      // Ack is checked first so a same-cycle ack beats the timeout.
      S_REQ: if (ack_s) begin
        retire  = 1'b1;
        state_d = S_REL;
      end else if (timeout_hit) begin
        retire  = 1'b1;
        err_set = 1'b1;
        state_d = S_REL;
      end
      S_REL: if (!ack_s) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Data register only loads on accept, so it is frozen while the far side samples it.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      o_sync_data  <= '0;
      o_sync_valid <= 1'b0;
      cnt_q        <= '0;
    end else begin
      if (accept) begin
        o_sync_data  <= i_data;
        o_sync_valid <= 1'b1;
      end else if (retire) begin
        o_sync_valid <= 1'b0;
      end
      if (accept)
        cnt_q <= '0;
      else if (state_q == S_REQ && cnt_q != CNT_MAX)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n)         o_err <= 1'b0;
    else if (err_set)   o_err <= 1'b1;
    else if (i_err_clr) o_err <= 1'b0;
  end

  assign o_ready = (state_q == S_IDLE) && !ack_s;
  assign o_busy  = (state_q != S_IDLE);
endmodule

// File: tb/tb_bus_sync_launch.sv
// Directed bench for bus_sync_launch with SYNC_STAGES=2 and TIMEOUT=8.
module tb_bus_sync_launch;
  localparam int DW = 32;
  localparam int ST = 2;
  localparam int TO = 8;

  logic          i_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [DW-1:0] o_sync_data;
  logic          o_sync_valid;
  logic          i_sync_ack;
  logic          o_busy;
  logic          o_err;
  logic          i_err_clr = 1'b0;

  logic inst_ack = 1'b0;
  logic man_ack  = 1'b0;
  assign i_sync_ack = inst_ack ? o_sync_valid : man_ack;

  int tests = 0;
  int fails = 0;

  bus_sync_launch #(.DWIDTH(DW), .SYNC_STAGES(ST), .TIMEOUT(TO)) dut (
    .i_clk        (i_clk),
    .rst_n        (rst_n),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .o_sync_data  (o_sync_data),
    .o_sync_valid (o_sync_valid),
    .i_sync_ack   (i_sync_ack),
    .o_busy       (o_busy),
    .o_err        (o_err),
    .i_err_clr    (i_err_clr)
  );

  always #5 i_clk = ~i_clk;

  // Request-edge recorder plus protocol watchers, sampled on the falling edge.
  int            req_cnt = 0;
  logic [DW-1:0] seen [$];
  int            overlap = 0;
  int            data_glitch = 0;
  logic          vld_prev = 1'b0;
  logic          busy_prev = 1'b0;
  logic [DW-1:0] data_prev = '0;
  always @(negedge i_clk) begin
    if (o_sync_valid && !vld_prev) begin
      req_cnt++;
      seen.push_back(o_sync_data);
    end
    if (o_ready && o_sync_valid) overlap++;
    if (rst_n && busy_prev && o_busy && o_sync_data !== data_prev) data_glitch++;
    vld_prev  = o_sync_valid;
    busy_prev = o_busy;
    data_prev = o_sync_data;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [DW-1:0] words [4];
  int base_cnt;
  int n;

  initial begin
    words[0] = 32'h1111_0001;
    words[1] = 32'h2222_0002;
    words[2] = 32'h3333_0003;
    words[3] = 32'h4444_0004;

    // Reset values
    #12;
    chk("rst_valid", o_sync_valid, 0);
    chk("rst_data",  o_sync_data, 0);
    chk("rst_err",   o_err, 0);
    chk("rst_busy",  o_busy, 0);
    chk("rst_ready", o_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();

    // Single transfer with a slow manual ack
    i_data = 32'hA5A5_0001; i_valid = 1'b1;
    chk("st_ready_pre", o_ready, 1);
    tick();                               // accept edge N
    i_valid = 1'b0; i_data = 32'hFFFF_FFFF;
    chk("st_valid_up", o_sync_valid, 1);
    chk("st_data",     o_sync_data, 32'hA5A5_0001);
    chk("st_busy",     o_busy, 1);
    chk("st_ready_lo", o_ready, 0);
    repeat (4) tick();                    // N+4
    man_ack = 1'b1;                       // before K=N+5
    tick();
    chk("st_valid_k", o_sync_valid, 1);
    tick();
    chk("st_valid_k1", o_sync_valid, 1);
    tick();                               // K+2
    chk("st_valid_fall", o_sync_valid, 0);
    chk("st_data_rel", o_sync_data, 32'hA5A5_0001);
    repeat (3) tick();
    chk("st_ready_rel", o_ready, 0);
    man_ack = 1'b0;                       // before M
    tick();
    chk("st_ready_m", o_ready, 0);
    tick();
    chk("st_ready_m1", o_ready, 0);
    tick();                               // M+2
    chk("st_ready_back", o_ready, 1);
    chk("st_busy_back",  o_busy, 0);
    chk("st_err", o_err, 0);

    // Back-to-back words with an instant ack
    inst_ack = 1'b1;
    base_cnt = req_cnt;
    for (int k = 0; k < 4; k++) begin
      i_data = words[k]; i_valid = 1'b1;
      n = 0;
      while (!o_ready && n < 20) begin tick(); n++; end
      tick();
      chk("b2b_data", o_sync_data, words[k]);
      chk("b2b_ready_lo", o_ready, 0);
    end
    i_valid = 1'b0;
    n = 0;
    while (o_busy && n < 40) begin tick(); n++; end
    chk("b2b_idle", o_busy, 0);
    inst_ack = 1'b0;
    chk("b2b_count", req_cnt - base_cnt, 4);
    for (int k = 0; k < 4; k++)
      chk("b2b_order", (base_cnt + k < seen.size()) ? seen[base_cnt + k] : 'x, words[k]);

    // Timeout: ack never comes
    tick();
    i_data = 32'h0BAD_0008; i_valid = 1'b1;
    tick();                               // accept edge N
    i_valid = 1'b0;
    repeat (7) tick();                    // N+7
    chk("to_valid_n7", o_sync_valid, 1);
    chk("to_err_n7",   o_err, 0);
    tick();                               // N+8
    chk("to_valid_fall", o_sync_valid, 0);
    chk("to_err_set",    o_err, 1);
    tick();
    chk("to_ready_back", o_ready, 1);
    chk("to_err_sticky", o_err, 1);
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
    chk("to_err_clr", o_err, 0);

    // Ack synchronized in the 8th S_REQ cycle: ack wins
    i_data = 32'h71E0_0008; i_valid = 1'b1;
    tick();                               // accept edge N
    i_valid = 1'b0;
    repeat (5) tick();                    // N+5
    man_ack = 1'b1;
    repeat (2) tick();                    // N+7
    chk("tie_valid_n7", o_sync_valid, 1);
    tick();                               // N+8
    chk("tie_valid_fall", o_sync_valid, 0);
    chk("tie_err", o_err, 0);
    man_ack = 1'b0;
    repeat (3) tick();
    chk("tie_ready", o_ready, 1);
    chk("tie_err_after", o_err, 0);

    // Stale ack held through reset
    man_ack = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("stale_rst_ready", o_ready, 1);
    tick(); tick();
    rst_n = 1'b1;
    repeat (ST) tick();
    chk("stale_ready_lo", o_ready, 0);
    repeat (3) tick();
    chk("stale_ready_hold", o_ready, 0);
    man_ack = 1'b0;
    tick();
    chk("stale_ready_m1", o_ready, 0);
    tick();
    chk("stale_ready_back", o_ready, 1);

    // Asynchronous reset mid-transfer
    i_data = 32'hDEAD_BEEF; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    chk("mid_valid", o_sync_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", o_sync_valid, 0);
    chk("mid_rst_data",  o_sync_data, 0);
    chk("mid_rst_busy",  o_busy, 0);
    chk("mid_rst_ready", o_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();

    chk("no_ready_valid_overlap", overlap, 0);
    chk("data_stable", data_glitch, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
